// File: rtl/irq_priority_resolver.sv
// irq_priority_resolver
// 8-level interrupt priority resolver in the style of an 8259-type controller.
// It holds the request register (irr), the in-service register (isr), a
// rotating lowest-priority pointer, the registered interrupt request and the
// acknowledged vector level.
//
// Build option: define AUTO_ROTATE_EN to enable auto rotation. When it is
// enabled and ar=1, every non-specific EOI that clears a bit moves the
// lowest-priority pointer to the level it cleared. When the macro is
// undefined, ar is ignored.
//
// The interrupt output is named int_o because "int" is a reserved word.

module irq_priority_resolver (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] ir,
  input  logic [7:0] Mask,
  input  logic       LTIM,
  input  logic       inta,
  input  logic       eoi,
  input  logic       seoi,
  input  logic       setpri,
  input  logic [2:0] lvl,
  input  logic       ar,
  output logic [7:0] irr,
  output logic [7:0] isr,
  output logic       int_o,
  output logic [2:0] Y
);

  // Result of a priority scan.
  // valid: at least one bit is set.
  // level: the winning IR level.
  // rank:  0 is the highest priority and 7 the lowest.
  typedef struct packed {
    logic       valid;
    logic [2:0] level;
    logic [2:0] rank;
  } pick_t;

  // Walk the levels from lp+1 (highest priority) round to lp (lowest).
  // Return the first set bit together with its rank.
  function automatic pick_t highestPick(input logic [7:0] vec,
                                        input logic [2:0] lp);
    pick_t      p;
    logic [2:0] idx;
    p       = '0;
    p.rank  = 3'd7;
    idx     = 3'd0;
    for (int k = 1; k <= 8; k++) begin
      idx = lp + 3'(k);
      if (!p.valid && vec[idx]) begin
        p.valid = 1'b1;
        p.level = idx;
        p.rank  = 3'(k - 1);
      end
    end
    return p;
  endfunction

  logic [7:0] ir_s_q,    ir_s_d;
  logic [7:0] ir_prev_q, ir_prev_d;
  logic [7:0] irr_q,     irr_d;
  logic [7:0] isr_q,     isr_d;
  logic       int_q,     int_d;
  logic [2:0] y_q,       y_d;
  logic [2:0] lp_q,      lp_d;

  pick_t      candPick;
  pick_t      isrPick;
  logic [7:0] ackSet;
  logic [7:0] eoiClr;
  logic [7:0] seoiClr;
  logic [7:0] riseDet;

  // Priority scans use the pre-edge pointer, so a cycle that moves lp still
  // resolves against the old ordering.
  always_comb begin
    candPick = highestPick(irr_q & ~Mask, lp_q);
    isrPick  = highestPick(isr_q, lp_q);
  end

  // Acknowledge sets the winning level. The EOI strobes clear from the
  // pre-edge isr. The clears are applied first, so a set and a clear on the
  // same bit leave the bit set.
  always_comb begin
    ackSet  = '0;
    eoiClr  = '0;
    seoiClr = '0;
    if (inta && candPick.valid) begin
      ackSet = 8'b1 << candPick.level;
    end
    if (eoi && isrPick.valid) begin
      eoiClr = 8'b1 << isrPick.level;
    end
    if (seoi) begin
      seoiClr = 8'b1 << lvl;
    end
    isr_d = (isr_q & ~(eoiClr | seoiClr)) | ackSet;
  end

  // Request capture works from the synchronised copy of ir.
  // In edge mode a bit is latched by a 0->1 transition and held while the
  // line stays high. In level mode irr simply follows the line.
  // In both modes the acknowledged bit is cleared in the acknowledge cycle.
  always_comb begin
    ir_s_d    = ir;
    ir_prev_d = ir_s_q;
    riseDet   = ir_s_q & ~ir_prev_q;
    if (LTIM) begin
      irr_d = ir_s_q & ~ackSet;
    end else begin
      irr_d = ir_s_q & (riseDet | irr_q) & ~ackSet;
    end
  end

  // Raise the interrupt when the candidate outranks everything in service.
  always_comb begin
    int_d = candPick.valid &&
            (!isrPick.valid || (candPick.rank < isrPick.rank));
  end

  // The vector is loaded only on acknowledge. If there is no candidate at
  // that point, the acknowledge is spurious and returns level 7.
  always_comb begin
    y_d = y_q;
    if (inta) begin
      y_d = candPick.valid ? candPick.level : 3'd7;
    end
  end

  // The lowest-priority pointer moves on setpri. When auto rotation is
  // enabled it also moves on an EOI that clears a bit. setpri takes
  // precedence over the rotation.
`ifdef AUTO_ROTATE_EN
  always_comb begin
    lp_d = lp_q;
    if (setpri) begin
      lp_d = lvl;
    end else if (ar && eoi && isrPick.valid) begin
      lp_d = isrPick.level;
    end
  end
`else
  logic unused_ar;
  assign unused_ar = ar;

  // Without auto rotation only setpri can move the pointer.
  always_comb begin
    lp_d = lp_q;
    if (setpri) begin
      lp_d = lvl;
    end
  end
`endif

  // State register. Reset wins over every strobe in the same cycle, so no
  // partial update of isr or any other register can happen.
  always_ff @(posedge clk) begin
    if (reset) begin
      ir_s_q    <= '0;
      ir_prev_q <= '0;
      irr_q     <= '0;
      isr_q     <= '0;
      int_q     <= 1'b0;
      y_q       <= 3'd7;
      lp_q      <= 3'd7;
    end else begin
      ir_s_q    <= ir_s_d;
      ir_prev_q <= ir_prev_d;
      irr_q     <= irr_d;
      isr_q     <= isr_d;
      int_q     <= int_d;
      y_q       <= y_d;
      lp_q      <= lp_d;
    end
  end

  assign irr   = irr_q;
  assign isr   = isr_q;
  assign int_o = int_q;
  assign Y     = y_q;

endmodule

// File: tb/tb_irq_priority_resolver.sv
// tb_irq_priority_resolver
// Directed bench for irq_priority_resolver.
// Expected output states are queued as each step is driven. They are then
// popped and compared against the registered outputs one time unit after
// the clock edge. Define AUTO_ROTATE_EN here too when the DUT is built with
// that option.

module tb_irq_priority_resolver;

  logic       clk;
  logic       reset;
  logic [7:0] ir;
  logic [7:0] Mask;
  logic       LTIM;
  logic       inta;
  logic       eoi;
  logic       seoi;
  logic       setpri;
  logic [2:0] lvl;
  logic       ar;
  logic [7:0] irr;
  logic [7:0] isr;
  logic       intO;
  logic [2:0] Y;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      tag;
    logic [7:0] irr;
    logic [7:0] isr;
    logic       intv;
    logic [2:0] y;
  } exp_t;

  exp_t sbQ[$];

  irq_priority_resolver dut (
    .clk    (clk),
    .reset  (reset),
    .ir     (ir),
    .Mask   (Mask),
    .LTIM   (LTIM),
    .inta   (inta),
    .eoi    (eoi),
    .seoi   (seoi),
    .setpri (setpri),
    .lvl    (lvl),
    .ar     (ar),
    .irr    (irr),
    .isr    (isr),
    .int_o  (intO),
    .Y      (Y)
  );

  // Free-running clock with rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance n clock edges and settle one time unit past the last edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive the one-cycle strobes for a single edge, then release them.
  task automatic applyStimulus(input logic iInta, input logic iEoi,
                               input logic iSeoi, input logic iSetpri,
                               input logic [2:0] iLvl);
    inta   = iInta;
    eoi    = iEoi;
    seoi   = iSeoi;
    setpri = iSetpri;
    lvl    = iLvl;
    tick(1);
    inta   = 1'b0;
    eoi    = 1'b0;
    seoi   = 1'b0;
    setpri = 1'b0;
    lvl    = 3'd0;
  endtask

  // Queue the output state the DUT should show after the current step.
  task automatic expectState(input string tag, input logic [7:0] eIrr,
                             input logic [7:0] eIsr, input logic eInt,
                             input logic [2:0] eY);
    exp_t e;
    e.tag  = tag;
    e.irr  = eIrr;
    e.isr  = eIsr;
    e.intv = eInt;
    e.y    = eY;
    sbQ.push_back(e);
  endtask

  // Pop the oldest expectation and compare all four outputs against it.
  task automatic checkOutput();
    exp_t e;
    checks++;
    assert (sbQ.size() > 0) else begin
      errors++;
      $error("[TB] FAIL scoreboard observed=empty expected=entry");
    end
    if (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      checks++;
      assert (irr === e.irr) else begin
        errors++;
        $error("[TB] FAIL %s.irr observed=%h expected=%h", e.tag, irr, e.irr);
      end
      checks++;
      assert (isr === e.isr) else begin
        errors++;
        $error("[TB] FAIL %s.isr observed=%h expected=%h", e.tag, isr, e.isr);
      end
      checks++;
      assert (intO === e.intv) else begin
        errors++;
        $error("[TB] FAIL %s.int observed=%b expected=%b", e.tag, intO, e.intv);
      end
      checks++;
      assert (Y === e.y) else begin
        errors++;
        $error("[TB] FAIL %s.Y observed=%0d expected=%0d", e.tag, Y, e.y);
      end
    end
  endtask

  task automatic expectAndCheck(input string tag, input logic [7:0] eIrr,
                                input logic [7:0] eIsr, input logic eInt,
                                input logic [2:0] eY);
    expectState(tag, eIrr, eIsr, eInt, eY);
    checkOutput();
  endtask

  initial begin
    reset  = 1'b1;
    ir     = 8'h00;
    Mask   = 8'h00;
    LTIM   = 1'b0;
    inta   = 1'b0;
    eoi    = 1'b0;
    seoi   = 1'b0;
    setpri = 1'b0;
    lvl    = 3'd0;
    ar     = 1'b0;
    tick(2);
    reset = 1'b0;
    expectAndCheck("reset", 8'h00, 8'h00, 1'b0, 3'd7);

    // Edge mode: ir=24 produces irr two edges later and int one edge after that.
    ir = 8'h24;
    tick(1);
    expectAndCheck("sync", 8'h00, 8'h00, 1'b0, 3'd7);
    tick(1);
    expectAndCheck("irrLatency", 8'h24, 8'h00, 1'b0, 3'd7);
    tick(1);
    expectAndCheck("intLatency", 8'h24, 8'h00, 1'b1, 3'd7);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    expectAndCheck("ackIr2", 8'h20, 8'h04, 1'b1, 3'd2);
    tick(1);
    expectAndCheck("blockedByIsr", 8'h20, 8'h04, 1'b0, 3'd2);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
    expectAndCheck("eoiIr2", 8'h20, 8'h00, 1'b0, 3'd2);
    tick(1);
    expectAndCheck("intAfterEoi", 8'h20, 8'h00, 1'b1, 3'd2);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    expectAndCheck("ackIr5", 8'h00, 8'h20, 1'b1, 3'd5);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
    ir = 8'h00;
    tick(3);
    expectAndCheck("idleA", 8'h00, 8'h00, 1'b0, 3'd5);

    // Edge mode: a line held high after acknowledge does not re-request.
    ir = 8'h08;
    tick(3);
    expectAndCheck("ir3Req", 8'h08, 8'h00, 1'b1, 3'd5);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    tick(3);
    expectAndCheck("ir3Held", 8'h00, 8'h08, 1'b0, 3'd3);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
    ir = 8'h00;
    tick(2);
    ir = 8'h08;
    tick(2);
    expectAndCheck("ir3ReEdge", 8'h08, 8'h00, 1'b0, 3'd3);
    ir = 8'h00;
    tick(4);
    expectAndCheck("idleB", 8'h00, 8'h00, 1'b0, 3'd3);

    // A masked request is visible in irr but never raises int; acknowledging
    // it is spurious.
    Mask = 8'h01;
    ir   = 8'h01;
    tick(3);
    expectAndCheck("maskedReq", 8'h01, 8'h00, 1'b0, 3'd3);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    expectAndCheck("spurious", 8'h01, 8'h00, 1'b0, 3'd7);
    ir   = 8'h00;
    Mask = 8'h00;
    tick(4);
    expectAndCheck("idleC", 8'h00, 8'h00, 1'b0, 3'd7);

    // Level mode: irr follows the line except in the acknowledge cycle.
    LTIM = 1'b1;
    ir   = 8'h02;
    tick(3);
    expectAndCheck("levelReq", 8'h02, 8'h00, 1'b1, 3'd7);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    expectAndCheck("levelAck", 8'h00, 8'h02, 1'b1, 3'd1);
    tick(1);
    expectAndCheck("levelReassert", 8'h02, 8'h02, 1'b0, 3'd1);
    ir = 8'h00;
    tick(2);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
    expectAndCheck("levelDone", 8'h00, 8'h00, 1'b0, 3'd1);
    LTIM = 1'b0;

    // Rotation. With the option enabled, ar=1 and each EOI moves the pointer.
    ar = 1'b1;
    ir = 8'h11;
    tick(3);
    expectAndCheck("rotReq", 8'h11, 8'h00, 1'b1, 3'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    expectAndCheck("rotAckIr0", 8'h10, 8'h01, 1'b1, 3'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
    expectAndCheck("rotEoi", 8'h10, 8'h00, 1'b0, 3'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    expectAndCheck("rotAckIr4", 8'h00, 8'h10, 1'b1, 3'd4);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 3'd3);
    ir = 8'h00;
    tick(2);
    ir = 8'h11;
    tick(3);
    expectAndCheck("setpriReq", 8'h11, 8'h00, 1'b1, 3'd4);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    expectAndCheck("setpriIr4Wins", 8'h01, 8'h10, 1'b1, 3'd4);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
    expectAndCheck("eoiIr4", 8'h01, 8'h00, 1'b0, 3'd4);
    ir = 8'h00;
    tick(2);
    ir = 8'h11;
    tick(3);
    expectAndCheck("arReq", 8'h11, 8'h00, 1'b1, 3'd4);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
`ifdef AUTO_ROTATE_EN
    expectAndCheck("arRotated", 8'h10, 8'h01, 1'b1, 3'd0);
`else
    expectAndCheck("arIgnored", 8'h01, 8'h10, 1'b1, 3'd4);
`endif
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
    ir = 8'h00;
    tick(3);
`ifdef AUTO_ROTATE_EN
    expectAndCheck("idleD", 8'h00, 8'h00, 1'b0, 3'd0);
`else
    expectAndCheck("idleD", 8'h00, 8'h00, 1'b0, 3'd4);
`endif
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 3'd7);
    ar = 1'b0;

    // inta together with seoi: the clear uses the old isr, the set uses the
    // candidate. Then reset in the next cycle, with strobes present.
    ir = 8'h04;
    tick(3);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    expectAndCheck("ackIr2b", 8'h00, 8'h04, 1'b1, 3'd2);
    ir = 8'h44;
    tick(2);
    expectAndCheck("ir6Pending", 8'h40, 8'h04, 1'b0, 3'd2);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 3'd2);
    expectAndCheck("ackSeoiMix", 8'h00, 8'h40, 1'b0, 3'd6);
    reset = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 3'd2);
    reset = 1'b0;
    ir    = 8'h00;
    expectAndCheck("midReset", 8'h00, 8'h00, 1'b0, 3'd7);

    // A set and a specific clear on the same level leave the bit set.
    ir = 8'h08;
    tick(3);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 3'd3);
    expectAndCheck("setWins", 8'h00, 8'h08, 1'b1, 3'd3);
    ir = 8'h00;
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/irq_priority_resolver.md
IRQ_PRIORITY_RESOLVER -- requirements
Module: irq_priority_resolver

Interface
REQ-001 SHALL have port: clk  in  1  single rising-edge clock; all state changes on this edge.
REQ-002 SHALL have port: reset  in  1  synchronous, active-high reset, sampled on clk.
REQ-003 SHALL have port: ir  in  8  raw interrupt request lines IR7..IR0.
REQ-004 SHALL have port: Mask  in  8  interrupt mask; 1 = masked.
REQ-005 SHALL have port: LTIM  in  1  trigger mode; 1 = level, 0 = edge.
REQ-006 SHALL have port: inta  in  1  one-cycle acknowledge strobe from control logic.
REQ-007 SHALL have port: eoi  in  1  one-cycle non-specific EOI strobe.
REQ-008 SHALL have port: seoi  in  1  one-cycle specific EOI strobe; level given by lvl.
REQ-009 SHALL have port: setpri  in  1  one-cycle strobe; loads lowest-priority pointer from lvl.
REQ-010 SHALL have port: lvl  in  3  level operand for seoi/setpri.
REQ-011 SHALL have port: ar  in  1  auto-rotate enable (see Configuration).
REQ-012 SHALL have port: irr  out  8  interrupt request register.
REQ-013 SHALL have port: isr  out  8  in-service register.
REQ-014 SHALL have port: int  out  1  registered interrupt request to control logic.
REQ-015 SHALL have port: Y  out  3  acknowledged vector level, registered.

Function
REQ-016 SHALL register ir into ir_s every cycle; all request logic uses ir_s, not ir.
REQ-017 SHALL, edge mode: set irr[i] on the cycle after ir_s[i] rises (0->1); hold it while ir_s[i]=1; clear it when ir_s[i]=0 or on acknowledge.
REQ-018 SHALL, level mode: set irr[i]=ir_s[i] every cycle, except irr[i]=0 in the acknowledge cycle.
REQ-019 SHALL keep lowest-priority pointer lp[2:0]; priority order, highest first: lp+1, lp+2 ... lp, all mod 8.
REQ-020 SHALL define the candidate as the highest-priority bit of irr & ~Mask.
REQ-021 SHALL set int=1 on the next clk when a candidate exists with priority higher than every set isr bit, or isr=0; otherwise int=0.
REQ-022 SHALL, on inta with a candidate C: set isr[C], clear irr[C], and load Y=C, all on that clk edge; Y is held until the next inta.
REQ-023 SHALL, on inta with no candidate: load Y=7 (spurious) and leave isr and irr unchanged.
REQ-024 SHALL, on eoi: clear the highest-priority set isr bit; if isr=0, no effect.
REQ-025 SHALL, on seoi: clear isr[lvl] regardless of priority.
REQ-026 SHALL, on setpri: load lp=lvl.
REQ-027 SHALL, when eoi or seoi coincides with inta in one cycle: compute the clear from pre-edge isr and the set from the candidate; if both target the same bit, the set wins.
REQ-028 SHALL, when setpri coincides with an eoi rotation (REQ-033): let setpri win.
REQ-029 SHALL evaluate the candidate and int with pre-edge lp in any cycle that changes lp.
REQ-030 SHALL define latency: ir rising at clk N gives irr at N+2 and int at N+3 (ir_s at N+1).

Reset
REQ-031 SHALL, on reset=1 at clk: set ir_s=0, irr=0, isr=0, int=0, Y=3'd7, lp=3'd7 (IR0 highest); strobes that same cycle are ignored.
REQ-032 SHALL, on reset mid-sequence: discard pending acknowledges and EOIs, with no partial isr update.

Configuration
REQ-033 SHALL, with macro AUTO_ROTATE_EN defined and ar=1: also load lp with the cleared level on each eoi that clears a bit (auto rotation); with ar=0, lp is unchanged by eoi.
REQ-034 SHALL, with AUTO_ROTATE_EN undefined: ignore ar, and change lp only via setpri and reset.

Verification
REQ-035 SHALL cover: reset, LTIM=0, Mask=0, ir=8'h24 at clk N -> irr=8'h24 at N+2, int=1 at N+3; inta -> isr=8'h04, Y=2, irr=8'h20.
REQ-036 SHALL cover: isr=8'h04, irr=8'h20 -> int=0; eoi -> isr=0, int=1 on the following clk; inta -> Y=5.
REQ-037 SHALL cover: LTIM=0, ir[3] held high after acknowledge -> irr[3] stays 0; ir[3] 0->1 again -> irr[3]=1 two clks later.
REQ-038 SHALL cover: Mask=8'h01, ir=8'h01 -> irr=8'h01, int stays 0; inta -> Y=7, isr=0.
REQ-039 SHALL cover: AUTO_ROTATE_EN defined, ar=1, ir=8'h11: acknowledge IR0 then eoi -> lp=0; then inta -> Y=4; setpri lvl=3, ir=8'h11 -> IR4 wins over IR0.
REQ-040 SHALL cover: inta and seoi lvl=2 in the same cycle with isr=8'h04, candidate 6 -> isr=8'h40, Y=6; reset asserted in the next cycle -> all outputs at reset values.
